ring_mem_requester: RTL and testbench
=====================================

Name: ring_mem_requester

Overview:
- Ring-side initiator for cache-line memory traffic; the requesting end of the Address/WriteData/RDreturn protocol answered by the ring memory controller.
- Sits in a core's ring stop between RingIn/RingOut and a local client (cache miss logic or DMA).
- On receiving the token, it appends one line request (read, or write with 8 data words) to the token train.
- For reads, it collects the 8 words returned on the RDreturn bus addressed to this core.

Parameters:
- LINE_WORDS, 8, words per cache line; fixed by the memory controller.
- CNT_W, 8, width of the train-pass counter; maximum forwarded train length is 2^CNT_W-1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- whichCore  in  4  this node's ring number; used as Source and RDdest match
- RingIn / SlotTypeIn / SourceIn  in  32/4/4  ring slot from the upstream node register
- RingOut / SlotTypeOut / SourceOut  out  32/4/4  combinational ring slot; the top level registers it
- RDreturn / RDdest  in  32/4  pipelined read-return bus
- req_valid  in  1  client request pending
- req_ready  out  1  request accepted this cycle
- req_write  in  1  1 = line write, 0 = line read
- req_excl  in  1  exclusive/modify intent; driven into Address bit 29
- req_addr  in  28  line address
- wd_data  in  32  next write word, first-word-fall-through from the client FIFO
- wd_rd  out  1  pop strobe for wd_data
- rd_valid  out  1  rd_data valid
- rd_data  out  32  returned read word
- done  out  1  one-cycle pulse when the request completes
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Slot types: Token=1, Address=2, WriteData=3, Null=7.
- Address word format: {1'b0 (resend), 1'b0, excl, read, addr[27:0]}, with SourceOut = whichCore.
- At most one request is outstanding.
- States:
  - IDLE: req_ready=1. When req_valid, latch write/excl/addr and go to WAIT_TOK.
  - WAIT_TOK: all slots pass through unchanged. On SlotTypeIn==Token with count C (RingIn), output Token with data C+N, where N=1 for a read and 1+LINE_WORDS for a write. Load the pass counter with C. Go to PASS if C!=0, otherwise to INS_ADDR.
  - PASS: forward slots unchanged and decrement the counter. At 1, go to INS_ADDR.
  - INS_ADDR: drive the Address slot. For a write, go to INS_DATA with a word count of 0; for a read, go to WAIT_RD.
  - INS_DATA: drive a WriteData slot from wd_data with SourceOut=whichCore and assert wd_rd. After LINE_WORDS words, pulse done and go to IDLE.
  - WAIT_RD: slots pass through unchanged. Each cycle with RDdest==whichCore, set rd_valid=1 and rd_data=RDreturn, and count. On the 8th word, done=1 in the same cycle and go to IDLE.
- Insertion rule: in INS_ADDR and INS_DATA the incoming slot must be Null. A non-Null incoming slot is overwritten (dropped) and proto_err is set.
- Resent Address slots (RingIn[31]=1) and any other traffic always pass through unchanged, in every state.
- Token count overflow: if C >= 2^CNT_W, set proto_err and treat C as 2^CNT_W-1.
- Stray read return: RDdest==whichCore outside WAIT_RD sets proto_err; the data is discarded.
- RDdest==0 never matches, because core numbering starts at 1.
- Latency: the Address slot leaves C+1 slot times after token arrival.
- Reset values: state IDLE; all counters 0; req_ready=0 during reset; wd_rd=0, rd_valid=0, done=0, proto_err=0.
- Ring output during reset is pure pass-through of RingIn/SlotTypeIn/SourceIn.
- Reset mid-operation abandons the request without completion; the client re-issues it.

Decomposition:
- Slot-type codes, Address bit positions (RESEND=31, EXCL=29, READ=28) and LINE_WORDS go in the shared ring definitions package used by the memory controller and the caches.
- One sub-module, ring_rd_collector: RDdest match, word counter and done generation; reusable by the I-cache.

Test Plan:
1. Read, empty train: whichCore=2, read addr 0x0000040. Token(C=0) arrives → same cycle Token(1); next cycle Address 0x10000040 src 2. Then RDdest=2 for 8 cycles carrying 0xA0..0xA7 → 8 rd_valid words in order, done on the 8th.
2. Write with train: token C=3 followed by 3 Address slots from core 4, excl=1, addr 0x123 → Token(12); the 3 slots are forwarded unchanged; then Address 0x20000123 and 8 WriteData words with 8 wd_rd pulses; done after the 8th word.
3. Resent Address 0x80000050 (type 2, src 5) arriving in every state → forwarded bit-exact; no state change.
4. Non-Null slot during INS_DATA word 3 → proto_err=1; the remaining 5 words are still emitted; done is asserted.
5. Stray RDdest=2 while IDLE → proto_err=1; rd_valid stays 0.
6. Reset asserted in PASS with 2 slots remaining → next cycle state IDLE and outputs mirror inputs; a new request then completes normally on the next token.

Source files
------------

// File: rtl/ring_mem_requester_pkg.sv
// Shared ring definitions: slot-type codes, Address word layout, line geometry
// and the requester FSM state type.
package ring_mem_requester_pkg;

    localparam int unsigned RING_LINE_WORDS = 8;

    localparam logic [3:0] SLOT_TOKEN      = 4'd1;
    localparam logic [3:0] SLOT_ADDRESS    = 4'd2;
    localparam logic [3:0] SLOT_WRITE_DATA = 4'd3;
    localparam logic [3:0] SLOT_NULL       = 4'd7;

    localparam int unsigned ADDR_RESEND_BIT = 31;
    localparam int unsigned ADDR_EXCL_BIT   = 29;
    localparam int unsigned ADDR_READ_BIT   = 28;

    typedef enum logic [2:0] {
        StIdle,
        StWaitTok,
        StPass,
        StInsAddr,
        StInsData,
        StWaitRd
    } req_state_e;

    // Address word: {resend=0, 0, excl, read, addr[27:0]}
    function automatic logic [31:0] make_addr_word(input logic excl, input logic read,
                                                   input logic [27:0] addr);
        logic [31:0] w;
        w = {4'b0000, addr};
        w[ADDR_EXCL_BIT] = excl;
        w[ADDR_READ_BIT] = read;
        return w;
    endfunction

    // Resent Address slots belong to someone else's retry and are never touched.
    function automatic logic is_resent(input logic [3:0] slot_type, input logic [31:0] data);
        return (slot_type == SLOT_ADDRESS) && data[ADDR_RESEND_BIT];
    endfunction

endpackage

// File: rtl/ring_rd_collector.sv
// Read-return collector: matches RDdest against this core, counts the words of
// one line and flags the last one. Returns that arrive while not collecting are
// reported as stray.
module ring_rd_collector
    import ring_mem_requester_pkg::*;
#(
    parameter int unsigned LINE_WORDS = RING_LINE_WORDS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        active,
    input  logic [3:0]  whichCore,
    input  logic [3:0]  RDdest,
    input  logic [31:0] RDreturn,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        stray
);

    localparam int unsigned WC_W = $clog2(LINE_WORDS);

    logic [WC_W-1:0] word_cnt_q;
    logic            hit;

    // Destination 0 is unused by core numbering, so it never matches.
    assign hit = !reset && (RDdest != 4'd0) && (RDdest == whichCore);

    // Accept or flag the return word in the cycle it appears on the bus.
    always_comb begin
        rd_valid = hit && active;
        rd_data  = rd_valid ? RDreturn : 32'd0;
        done     = rd_valid && (word_cnt_q == WC_W'(LINE_WORDS - 1));
        stray    = hit && !active;
    end

    // Word counter restarts whenever collection is not in progress.
    always_ff @(posedge clock) begin
        if (reset || !active) begin
            word_cnt_q <= '0;
        end else if (rd_valid) begin
            word_cnt_q <= done ? '0 : word_cnt_q + WC_W'(1);
        end
    end

endmodule

// File: rtl/ring_mem_requester.sv
// Ring-side initiator for cache-line memory traffic. Grabs the token, grows the
// train count by the slots it needs, waits out the existing train, then inserts
// one Address slot (plus write data) and, for reads, collects the returned line.
module ring_mem_requester
    import ring_mem_requester_pkg::*;
#(
    parameter int unsigned LINE_WORDS = RING_LINE_WORDS,
    parameter int unsigned CNT_W      = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  whichCore,
    input  logic [31:0] RingIn,
    input  logic [3:0]  SlotTypeIn,
    input  logic [3:0]  SourceIn,
    output logic [31:0] RingOut,
    output logic [3:0]  SlotTypeOut,
    output logic [3:0]  SourceOut,
    input  logic [31:0] RDreturn,
    input  logic [3:0]  RDdest,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_excl,
    input  logic [27:0] req_addr,
    input  logic [31:0] wd_data,
    output logic        wd_rd,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        proto_err
);

    localparam int unsigned WC_W        = $clog2(LINE_WORDS);
    localparam logic [31:0] READ_SLOTS  = 32'd1;
    localparam logic [31:0] WRITE_SLOTS = 32'(LINE_WORDS + 1);

    req_state_e       state_q;
    logic [CNT_W-1:0] pass_cnt_q;
    logic [WC_W-1:0]  word_cnt_q;
    logic             write_q;
    logic             excl_q;
    logic [27:0]      addr_q;
    logic             proto_err_q;

    logic             resent;
    logic             tok_take;
    logic             tok_ovf;
    logic [CNT_W-1:0] tok_cnt;
    logic             ins_fire;
    logic             ins_last;
    logic             drop;
    logic             rd_done;
    logic             rd_stray;

    assign resent   = is_resent(SlotTypeIn, RingIn);
    assign tok_take = (state_q == StWaitTok) && (SlotTypeIn == SLOT_TOKEN);
    // Counts beyond the pass counter's range saturate and are reported.
    assign tok_ovf  = (RingIn >> CNT_W) != 32'd0;
    assign tok_cnt  = tok_ovf ? '1 : RingIn[CNT_W-1:0];
    // Insertion is deferred while a resent Address slot occupies the ring.
    assign ins_fire = !reset && !resent && ((state_q == StInsAddr) || (state_q == StInsData));
    assign ins_last = (state_q == StInsData) && (word_cnt_q == WC_W'(LINE_WORDS - 1));
    assign drop     = ins_fire && (SlotTypeIn != SLOT_NULL);

    assign req_ready = !reset && (state_q == StIdle);
    assign done      = (ins_fire && ins_last) || rd_done;
    assign proto_err = proto_err_q;

    ring_rd_collector #(
        .LINE_WORDS (LINE_WORDS)
    ) u_rd_collector (
        .clock     (clock),
        .reset     (reset),
        .active    (state_q == StWaitRd),
        .whichCore (whichCore),
        .RDdest    (RDdest),
        .RDreturn  (RDreturn),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (rd_done),
        .stray     (rd_stray)
    );

    // Ring slot mux: pass-through unless rewriting the token or inserting our slot.
    always_comb begin
        RingOut     = RingIn;
        SlotTypeOut = SlotTypeIn;
        SourceOut   = SourceIn;
        wd_rd       = 1'b0;
        if (!reset) begin
            unique case (state_q)
                StWaitTok: begin
                    if (tok_take) begin
                        RingOut = 32'(tok_cnt) + (write_q ? WRITE_SLOTS : READ_SLOTS);
                    end
                end
                StInsAddr: begin
                    if (!resent) begin
                        RingOut     = make_addr_word(excl_q, !write_q, addr_q);
                        SlotTypeOut = SLOT_ADDRESS;
                        SourceOut   = whichCore;
                    end
                end
                StInsData: begin
                    if (!resent) begin
                        RingOut     = wd_data;
                        SlotTypeOut = SLOT_WRITE_DATA;
                        SourceOut   = whichCore;
                        wd_rd       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Request sequencing, pass/word counters and the sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            pass_cnt_q  <= '0;
            word_cnt_q  <= '0;
            write_q     <= 1'b0;
            excl_q      <= 1'b0;
            addr_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (drop || rd_stray || (tok_take && tok_ovf)) begin
                proto_err_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        excl_q  <= req_excl;
                        addr_q  <= req_addr;
                        state_q <= StWaitTok;
                    end
                end
                StWaitTok: begin
                    if (tok_take) begin
                        pass_cnt_q <= tok_cnt;
                        state_q    <= (tok_cnt != '0) ? StPass : StInsAddr;
                    end
                end
                StPass: begin
                    // Resent slots are not part of the train being skipped.
                    if (!resent) begin
                        pass_cnt_q <= pass_cnt_q - CNT_W'(1);
                        if (pass_cnt_q == CNT_W'(1)) begin
                            state_q <= StInsAddr;
                        end
                    end
                end
                StInsAddr: begin
                    if (!resent) begin
                        word_cnt_q <= '0;
                        state_q    <= write_q ? StInsData : StWaitRd;
                    end
                end
                StInsData: begin
                    if (!resent) begin
                        word_cnt_q <= word_cnt_q + WC_W'(1);
                        if (ins_last) begin
                            state_q <= StIdle;
                        end
                    end
                end
                StWaitRd: begin
                    if (rd_done) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_mem_requester.sv
// Bench for ring_mem_requester: each request is modelled as the slot sequence it
// should produce (token rewrite, untouched train, Address, data words) plus the
// read-return stream, with resent slots treated as transparent.
module tb_ring_mem_requester;
    import ring_mem_requester_pkg::*;

    localparam int CNT_W = 8;
    localparam int MAX_C = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [3:0]  typ;
        logic [3:0]  src;
        logic [31:0] dat;
    } slot_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  whichCore;
    logic [31:0] RingIn, RingOut, RDreturn, wd_data, rd_data;
    logic [3:0]  SlotTypeIn, SourceIn, SlotTypeOut, SourceOut, RDdest;
    logic        req_valid, req_ready, req_write, req_excl;
    logic [27:0] req_addr;
    logic        wd_rd, rd_valid, done, proto_err;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference state of the requester as seen from outside.
    bit m_idle;
    bit m_perr;
    int resent_rate  = 0;
    bit fixed_resent = 1'b0;

    always #5 clock = ~clock;

    ring_mem_requester dut (
        .clock       (clock),
        .reset       (reset),
        .whichCore   (whichCore),
        .RingIn      (RingIn),
        .SlotTypeIn  (SlotTypeIn),
        .SourceIn    (SourceIn),
        .RingOut     (RingOut),
        .SlotTypeOut (SlotTypeOut),
        .SourceOut   (SourceOut),
        .RDreturn    (RDreturn),
        .RDdest      (RDdest),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_excl    (req_excl),
        .req_addr    (req_addr),
        .wd_data     (wd_data),
        .wd_rd       (wd_rd),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .done        (done),
        .proto_err   (proto_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic slot_t null_slot();
        slot_t s;
        s.typ = SLOT_NULL;
        s.src = 4'd0;
        s.dat = 32'd0;
        return s;
    endfunction

    // Other nodes' traffic: never a token, never a resent Address.
    function automatic slot_t rand_foreign(input bit non_null);
        slot_t s;
        int    k;
        k = non_null ? $urandom_range(2) : $urandom_range(3);
        case (k)
            0:       s.typ = SLOT_ADDRESS;
            1:       s.typ = SLOT_WRITE_DATA;
            2:       s.typ = 4'd5;
            default: s.typ = SLOT_NULL;
        endcase
        s.src = 4'($urandom_range(15));
        s.dat = $urandom;
        if (s.typ == SLOT_ADDRESS) s.dat[31] = 1'b0;
        return s;
    endfunction

    function automatic logic [3:0] other_core();
        return 4'((int'(whichCore) + 1 + $urandom_range(13)) % 16);
    endfunction

    task automatic drive_slot(input slot_t s);
        SlotTypeIn = s.typ;
        SourceIn   = s.src;
        RingIn     = s.dat;
    endtask

    task automatic check_ring(input string tag, input slot_t e);
        check_val({tag, " type"}, SlotTypeOut, e.typ);
        check_val({tag, " src"}, SourceOut, e.src);
        check_val({tag, " data"}, RingOut, e.dat);
    endtask

    // One slot time with no read return on the bus.
    task automatic ring_cycle(input slot_t din, input slot_t dexp, input logic [31:0] wdat,
                              input logic exp_wd, input logic exp_done, input string tag);
        drive_slot(din);
        wd_data = wdat;
        #4;
        check_ring(tag, dexp);
        check_val({tag, " wd_rd"}, wd_rd, exp_wd);
        check_val({tag, " done"}, done, exp_done);
        check_val({tag, " rd_valid"}, rd_valid, 1'b0);
        check_val({tag, " req_ready"}, req_ready, m_idle);
        @(posedge clock);
        #1;
    endtask

    task automatic maybe_resent();
        slot_t r;
        if (resent_rate == 0) return;
        if ($urandom_range(resent_rate - 1) != 0) return;
        r.typ = SLOT_ADDRESS;
        r.src = fixed_resent ? 4'd5 : 4'($urandom_range(15));
        r.dat = fixed_resent ? 32'h8000_0050 : (32'h8000_0000 | $urandom);
        ring_cycle(r, r, $urandom, 1'b0, 1'b0, "resent");
    endtask

    // One slot time with a read-return word on the bus; ring is foreign traffic.
    task automatic rd_cycle(input logic [3:0] dest, input logic [31:0] data, input logic exp_v,
                            input logic exp_done, input string tag);
        slot_t s;
        maybe_resent();
        s = rand_foreign(1'b0);
        drive_slot(s);
        RDdest   = dest;
        RDreturn = data;
        #4;
        check_ring(tag, s);
        check_val({tag, " rd_valid"}, rd_valid, exp_v);
        if (exp_v) check_val({tag, " rd_data"}, rd_data, data);
        check_val({tag, " done"}, done, exp_done);
        check_val({tag, " wd_rd"}, wd_rd, 1'b0);
        check_val({tag, " req_ready"}, req_ready, m_idle);
        @(posedge clock);
        #1;
        RDdest = 4'd0;
    endtask

    task automatic apply_reset();
        slot_t s;
        s         = rand_foreign(1'b0);
        reset     = 1'b1;
        req_valid = 1'b0;
        drive_slot(s);
        RDdest    = whichCore;
        RDreturn  = $urandom;
        #4;
        check_ring("reset", s);
        check_val("reset req_ready", req_ready, 1'b0);
        check_val("reset wd_rd", wd_rd, 1'b0);
        check_val("reset rd_valid", rd_valid, 1'b0);
        check_val("reset done", done, 1'b0);
        @(posedge clock);
        #1;
        reset  = 1'b0;
        RDdest = 4'd0;
        m_idle = 1'b1;
        m_perr = 1'b0;
        check_val("reset proto_err", proto_err, 1'b0);
    endtask

    // Full request: handshake, token, train, Address, then data out or line in.
    task automatic run_req(input logic wr, input logic ex, input logic [27:0] ad, input int c,
                           input int gap, input int err_word, input int abort_after,
                           input logic [31:0] rd_base, input logic [3:0] train_src,
                           input string tag);
        slot_t       si, se;
        int          eff;
        logic [31:0] w;
        maybe_resent();
        req_valid = 1'b1;
        req_write = wr;
        req_excl  = ex;
        req_addr  = ad;
        si = rand_foreign(1'b0);
        ring_cycle(si, si, $urandom, 1'b0, 1'b0, {tag, " issue"});
        // Scramble the request fields to catch anything not latched.
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_excl  = 1'($urandom);
        req_addr  = 28'($urandom);
        m_idle    = 1'b0;
        for (int i = 0; i < gap; i++) begin
            maybe_resent();
            si = rand_foreign(1'b0);
            ring_cycle(si, si, $urandom, 1'b0, 1'b0, {tag, " wait"});
        end
        eff = (c > MAX_C) ? MAX_C : c;
        maybe_resent();
        si.typ = SLOT_TOKEN;
        si.src = 4'($urandom_range(15));
        si.dat = 32'(c);
        se     = si;
        se.dat = 32'(eff) + (wr ? 32'(RING_LINE_WORDS + 1) : 32'd1);
        ring_cycle(si, se, $urandom, 1'b0, 1'b0, {tag, " token"});
        if (c > MAX_C) m_perr = 1'b1;
        for (int i = 0; i < eff; i++) begin
            if (abort_after == i) begin
                apply_reset();
                return;
            end
            maybe_resent();
            if (train_src != 4'd0) begin
                si.typ = SLOT_ADDRESS;
                si.src = train_src;
                si.dat = $urandom & 32'h7fff_ffff;
            end else begin
                si = rand_foreign(1'b0);
            end
            ring_cycle(si, si, $urandom, 1'b0, 1'b0, {tag, " train"});
        end
        maybe_resent();
        se.typ = SLOT_ADDRESS;
        se.src = whichCore;
        se.dat = {2'b00, ex, ~wr, ad};
        ring_cycle(null_slot(), se, $urandom, 1'b0, 1'b0, {tag, " addr"});
        if (wr) begin
            for (int i = 0; i < int'(RING_LINE_WORDS); i++) begin
                maybe_resent();
                w = $urandom;
                if (i == err_word) begin
                    si     = rand_foreign(1'b1);
                    m_perr = 1'b1;
                end else begin
                    si = null_slot();
                end
                se.typ = SLOT_WRITE_DATA;
                se.src = whichCore;
                se.dat = w;
                ring_cycle(si, se, w, 1'b1, i == int'(RING_LINE_WORDS) - 1, {tag, " wdata"});
            end
        end else begin
            for (int i = 0; i < int'(RING_LINE_WORDS); i++) begin
                if (rd_base == 32'd0) begin
                    int g;
                    g = $urandom_range(2);
                    for (int k = 0; k < g; k++) rd_cycle(other_core(), $urandom, 1'b0, 1'b0,
                                                         {tag, " rd gap"});
                    w = $urandom;
                end else begin
                    w = rd_base + 32'(i);
                end
                rd_cycle(whichCore, w, 1'b1, i == int'(RING_LINE_WORDS) - 1, {tag, " rd word"});
            end
        end
        m_idle = 1'b1;
        check_val({tag, " proto_err"}, proto_err, m_perr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        whichCore  = 4'd2;
        RingIn     = 32'd0;
        SlotTypeIn = SLOT_NULL;
        SourceIn   = 4'd0;
        RDreturn   = 32'd0;
        RDdest     = 4'd0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_excl   = 1'b0;
        req_addr   = 28'd0;
        wd_data    = 32'd0;
        m_idle     = 1'b1;
        m_perr     = 1'b0;
        @(posedge clock);
        #1;
        apply_reset();

        // Read on an empty train.
        run_req(1'b0, 1'b0, 28'h000_0040, 0, 0, -1, -1, 32'h0000_00A0, 4'd0, "t1");
        // Exclusive write behind a 3-slot train from core 4.
        run_req(1'b1, 1'b1, 28'h000_0123, 3, 1, -1, -1, 32'd0, 4'd4, "t2");

        // Resent Address slot ahead of every slot time, in every state.
        resent_rate  = 1;
        fixed_resent = 1'b1;
        run_req(1'b1, 1'b0, 28'h0AB_CDEF, 2, 1, -1, -1, 32'd0, 4'd0, "t3w");
        run_req(1'b0, 1'b1, 28'h765_4321, 1, 1, -1, -1, 32'd0, 4'd0, "t3r");
        resent_rate  = 0;
        fixed_resent = 1'b0;

        // Occupied slot at the third write word.
        run_req(1'b1, 1'b0, 28'($urandom), 2, 0, 2, -1, 32'd0, 4'd0, "t4");
        apply_reset();

        // Destination 0 never matches, even for a core numbered 0.
        whichCore = 4'd0;
        rd_cycle(4'd0, 32'h1234_5678, 1'b0, 1'b0, "t5 dest0");
        check_val("t5 dest0 proto_err", proto_err, 1'b0);
        whichCore = 4'd2;
        // Stray return while idle.
        rd_cycle(4'd2, 32'hDEAD_BEEF, 1'b0, 1'b0, "t5 stray");
        check_val("t5 stray proto_err", proto_err, 1'b1);
        apply_reset();

        // Reset while two train slots remain, then a clean request.
        run_req(1'b1, 1'b0, 28'h000_0777, 4, 0, -1, 2, 32'd0, 4'd0, "t6 abort");
        run_req(1'b0, 1'b0, 28'h000_0888, 1, 0, -1, -1, 32'd0, 4'd0, "t6 retry");

        // Token count past the counter range saturates.
        run_req(1'b0, 1'b0, 28'h000_0999, 300, 0, -1, -1, 32'd0, 4'd0, "ovf");
        apply_reset();

        // Randomized requests with scattered resent slots.
        resent_rate = 5;
        for (int n = 0; n < 40; n++) begin
            whichCore = 4'($urandom_range(15, 1));
            run_req(1'($urandom), 1'($urandom), 28'($urandom), $urandom_range(6),
                    $urandom_range(3), -1, -1, 32'd0, 4'd0, "rand");
        end
        resent_rate = 0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
